// File: rtl/morph_stream_3x3_if.sv
// Pixel stream bundle for morph_stream_3x3: per-frame config, input stream and output stream.
// master = upstream/downstream environment, slave = the filter.
interface morph_stream_3x3_if #(
    parameter int PIX_W = 8
);
    logic             cfg_mode;
    logic [PIX_W-1:0] cfg_thresh;
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_eof;
    logic [PIX_W-1:0] out_pixel;

    modport master (
        output cfg_mode, cfg_thresh, in_valid, in_sof, in_pixel, out_ready,
        input  in_ready, out_valid, out_sof, out_eof, out_pixel
    );

    modport slave (
        input  cfg_mode, cfg_thresh, in_valid, in_sof, in_pixel, out_ready,
        output in_ready, out_valid, out_sof, out_eof, out_pixel
    );
endinterface

// File: rtl/morph_stream_3x3.sv
// Streaming 3x3 binary erosion/dilation over a thresholded raster pixel stream.
// One output per accepted pixel; output at (r,c) is the window centred on (r-1,c-1).
module morph_stream_3x3 #(
    parameter int PIX_W      = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter bit BORDER_ERO = 1'b0,
    parameter bit BORDER_DIL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    morph_stream_3x3_if.slave   bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    col, pos_col;
    logic [RW-1:0]    row, pos_row;
    logic             mode_q, pos_mode;
    logic [PIX_W-1:0] thresh_q, pos_thresh;
    logic             accept, take, frame_end;
    logic [IMG_W-1:0] lb0, lb1;
    logic [2:0]       win_a, win_b, win_c;
    logic             bit_in, result;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (take) state_nxt = frame_end ? IDLE : ACTIVE;
    end

    // An sof pixel is always (0,0) with freshly sampled config, in either state.
    always_comb begin
        take       = 1'b0;
        pos_col    = '0;
        pos_row    = '0;
        pos_mode   = mode_q;
        pos_thresh = thresh_q;
        if (accept) begin
            if (bus.in_sof) begin
                take       = 1'b1;
                pos_mode   = bus.cfg_mode;
                pos_thresh = bus.cfg_thresh;
            end else if (state == ACTIVE) begin
                take    = 1'b1;
                pos_col = col;
                pos_row = row;
            end
        end
    end

    assign frame_end = take && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    assign bit_in    = bus.in_pixel > pos_thresh;
    assign win_c     = {lb1[pos_col], lb0[pos_col], bit_in};

    always_comb begin
        if (pos_row < RW'(2) || pos_col < CW'(2))
            result = pos_mode ? BORDER_DIL : BORDER_ERO;
        else if (pos_mode)
            result = |{win_a, win_b, win_c};
        else
            result = &{win_a, win_b, win_c};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sof   <= 1'b0;
            bus.out_eof   <= 1'b0;
            bus.out_pixel <= '0;
            col           <= '0;
            row           <= '0;
            mode_q        <= 1'b0;
            thresh_q      <= {1'b0, {(PIX_W-1){1'b1}}};
        end else begin
            if (take) begin
                bus.out_valid <= 1'b1;
                bus.out_sof   <= bus.in_sof;
                bus.out_eof   <= frame_end;
                bus.out_pixel <= {PIX_W{result}};
                if (bus.in_sof) begin
                    mode_q   <= bus.cfg_mode;
                    thresh_q <= bus.cfg_thresh;
                end
                if (frame_end) begin
                    col <= '0;
                    row <= '0;
                end else if (pos_col == COL_LAST) begin
                    col <= '0;
                    row <= pos_row + 1'b1;
                end else begin
                    col <= pos_col + 1'b1;
                    row <= pos_row;
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    // Line buffers and window need no reset: the row/col border mask hides stale bits.
    always_ff @(posedge clk) begin
        if (take) begin
            lb0[pos_col] <= bit_in;
            lb1[pos_col] <= lb0[pos_col];
            win_a        <= win_b;
            win_b        <= win_c;
        end
    end
endmodule

// File: tb/tb_morph_stream_3x3.sv
// Directed bench for morph_stream_3x3 on an 8x4 image: vector table plus backpressure and reset sequences.
module tb_morph_stream_3x3;
    localparam int W = 8;
    localparam int H = 4;

    typedef struct {
        logic       sof;
        logic       mode;
        logic [7:0] thresh;
        logic [7:0] pix;
        logic [7:0] exp_pix;
        logic       exp_sof;
        logic       exp_eof;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    morph_stream_3x3_if #(.PIX_W(8)) bus ();

    morph_stream_3x3 #(
        .PIX_W(8), .IMG_W(W), .IMG_H(H), .BORDER_ERO(1'b0), .BORDER_DIL(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // kind 0: all bright, 1: single spot at (2,3) on 127 background, 2: hole at (2,2) in 255
    function automatic logic [7:0] pix_of(int kind, int r, int c);
        case (kind)
            0:       return 8'd200;
            1:       return (r == 2 && c == 3) ? 8'd128 : 8'd127;
            default: return (r == 2 && c == 2) ? 8'd0 : 8'd255;
        endcase
    endfunction

    function automatic logic exp_of(int kind, int r, int c);
        case (kind)
            0:       return (r >= 2 && c >= 2);
            1:       return (r >= 2 && c >= 3 && c <= 5);
            default: return (r >= 2 && c >= 5);
        endcase
    endfunction

    // Non-sof pixels carry the opposite mode and threshold 0 so unlatched config shows up.
    task automatic push_frame(int kind, logic mode, int npix);
        vec_t v;
        for (int k = 0; k < npix; k++) begin
            int r = k / W;
            int c = k % W;
            v.sof     = (k == 0);
            v.mode    = (k == 0) ? mode : ~mode;
            v.thresh  = (k == 0) ? 8'd127 : 8'd0;
            v.pix     = pix_of(kind, r, c);
            v.exp_pix = exp_of(kind, r, c) ? 8'hFF : 8'h00;
            v.exp_sof = (k == 0);
            v.exp_eof = (r == H - 1 && c == W - 1);
            vecs.push_back(v);
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive(vec_t v, logic valid);
        bus.in_valid   = valid;
        bus.in_sof     = v.sof;
        bus.cfg_mode   = v.mode;
        bus.cfg_thresh = v.thresh;
        bus.in_pixel   = v.pix;
    endtask

    initial begin
        vec_t       bp[$];
        vec_t       v;
        int         idx, oidx, cyc;
        logic       prev_stall;
        logic [7:0] s_pix;
        logic       s_sof, s_eof;

        bus.in_valid   = 1'b1;
        bus.in_sof     = 1'b1;
        bus.in_pixel   = 8'd200;
        bus.cfg_mode   = 1'b0;
        bus.cfg_thresh = 8'd127;
        bus.out_ready  = 1'b1;

        push_frame(0, 1'b0, W * H);
        push_frame(1, 1'b1, W * H);
        push_frame(2, 1'b0, W * H);
        push_frame(0, 1'b0, W + 5);     // aborted at (1,5) by the next sof
        push_frame(1, 1'b1, W * H);
        for (int k = 2 * W * H; k < 3 * W * H; k++) bp.push_back(vecs[k]);

        // reset held with traffic present
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_pixel", 32'(bus.out_pixel), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_sof_eof", 32'({bus.out_sof, bus.out_eof}), 0);

        // idle drops non-sof pixels
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_drop", 32'(bus.out_valid), 0);
        end

        // main table, continuous stream, out_ready=1
        foreach (vecs[i]) begin
            drive(vecs[i], 1'b1);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 1);
            chk($sformatf("v%0d_pix", i), 32'(bus.out_pixel), 32'(vecs[i].exp_pix));
            chk($sformatf("v%0d_flags", i), 32'({bus.out_sof, bus.out_eof}),
                32'({vecs[i].exp_sof, vecs[i].exp_eof}));
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("drain_valid", 32'(bus.out_valid), 0);

        // backpressure on the hole frame
        idx = 0; oidx = 0; cyc = 0; prev_stall = 1'b0;
        s_pix = '0; s_sof = 1'b0; s_eof = 1'b0;
        while (oidx < W * H && cyc < 2000) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_hold", 32'({bus.out_pixel, bus.out_sof, bus.out_eof}),
                    32'({s_pix, s_sof, s_eof}));
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            if (idx < W * H) drive(bp[idx], 1'($urandom_range(0, 1)));
            else             bus.in_valid = 1'b0;
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("bp%0d_pix", oidx), 32'(bus.out_pixel), 32'(bp[oidx].exp_pix));
                chk($sformatf("bp%0d_flags", oidx), 32'({bus.out_sof, bus.out_eof}),
                    32'({bp[oidx].exp_sof, bp[oidx].exp_eof}));
                oidx++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            prev_stall = bus.out_valid && !bus.out_ready;
            s_pix = bus.out_pixel; s_sof = bus.out_sof; s_eof = bus.out_eof;
            cyc++;
        end
        chk("bp_out_count", 32'(oidx), W * H);
        chk("bp_in_count", 32'(idx), W * H);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_no_extra", 32'(bus.out_valid), 0);

        // reset in the middle of a frame
        for (int k = 0; k < 10; k++) begin
            drive(vecs[k], 1'b1);
            @(negedge clk);
        end
        rst_n = 1'b0;
        bus.in_sof = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(bus.out_valid), 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_idle", 32'(bus.out_valid), 0);
        end
        v = vecs[0];
        v.mode = 1'b1;
        drive(v, 1'b1);
        @(negedge clk);
        chk("midrst_restart_valid", 32'(bus.out_valid), 1);
        chk("midrst_restart_sof", 32'(bus.out_sof), 1);
        chk("midrst_restart_pix", 32'(bus.out_pixel), 0);
        bus.in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
